// File: rtl/crc_chk_pkg.sv
// -----------------------------------------------------------------------------
// crc_chk_pkg
// Shared definitions for the serial CRC field checker:
//   - crc_state_e      : checker FSM states
//   - CANXL_*_POLY     : CAN XL generator polynomials (implicit x^CRC_W omitted)
//   - CRC_DEFAULT_INIT : default CRC register seed
//   - clog2()          : ceiling log2, used to size the CRC field bit counter
// -----------------------------------------------------------------------------
package crc_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        RCV   = 2'd2,
        CHECK = 2'd3
    } crc_state_e;

    localparam logic [31:0] CANXL_FCRC_POLY  = 32'h1F1B3D6B;
    localparam logic [12:0] CANXL_PCRC_POLY  = 13'h1D0F;
    localparam logic [31:0] CRC_DEFAULT_INIT = 32'hFFFFFFFF;

    // Ceiling log2, never smaller than 1 so it can size a vector directly.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/crc_serial_lfsr.sv
// -----------------------------------------------------------------------------
// crc_serial_lfsr
// Bit-serial CRC register (Galois form, MSB first).
// Ports:
//   clk    : clock
//   g_rst  : asynchronous active-high reset, loads INIT
//   load   : reload INIT (has priority over shift)
//   shift  : hash din into the register this cycle
//   din    : serial data bit
//   crc    : current CRC register contents (CRC_W bits)
// -----------------------------------------------------------------------------
module crc_serial_lfsr
    import crc_chk_pkg::*;
#(
    parameter int unsigned CRC_W = 32,
    parameter logic [31:0] POLY  = CANXL_FCRC_POLY,
    parameter logic [31:0] INIT  = CRC_DEFAULT_INIT
) (
    input  logic             clk,
    input  logic             g_rst,
    input  logic             load,
    input  logic             shift,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_W = INIT[CRC_W-1:0];

    logic fb;

    assign fb = crc[CRC_W-1] ^ din;

    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            crc <= INIT_W;
        end else if (load) begin
            crc <= INIT_W;
        end else if (shift) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : '0);
        end
    end

endmodule

// File: rtl/crc_field_checker.sv
// -----------------------------------------------------------------------------
// crc_field_checker
// Serial CRC check stage for the CAN XL receive path (after destuffing).
// Hashes the destuffed bit stream, captures the transmitted CRC field and
// compares the two. Used for both PCRC and FCRC through parameters.
// Ports:
//   clk, g_rst : clock, asynchronous active-high reset
//   frm_start  : new frame strobe, reloads the CRC engine
//   abort      : discard the current frame (wins over frm_start)
//   bit_vld    : bit_in carries one destuffed bit this cycle
//   bit_in     : received bit, MSB first
//   crc_fld    : marks bit_in as the first CRC field bit (used in CALC only)
//   chk_en     : 0 suppresses mismatch reporting
//   crc_value  : current computed CRC register
//   crc_done   : one-cycle pulse, compare finished
//   crc_ok     : one-cycle pulse with crc_done on a match
//   crc_err    : mismatch flag, held until frm_start or abort
//   err_cnt    : saturating count of reported mismatches
// -----------------------------------------------------------------------------
module crc_field_checker
    import crc_chk_pkg::*;
#(
    parameter int unsigned CRC_W     = 32,
    parameter logic [31:0] POLY      = CANXL_FCRC_POLY,
    parameter logic [31:0] INIT      = CRC_DEFAULT_INIT,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 g_rst,
    input  logic                 frm_start,
    input  logic                 abort,
    input  logic                 bit_vld,
    input  logic                 bit_in,
    input  logic                 crc_fld,
    input  logic                 chk_en,
    output logic [CRC_W-1:0]     crc_value,
    output logic                 crc_done,
    output logic                 crc_ok,
    output logic                 crc_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // bit_cnt must hold 0..CRC_W
    localparam int unsigned          BCNT_W   = clog2(CRC_W + 1);
    localparam logic [BCNT_W-1:0]    LAST_BIT = BCNT_W'(CRC_W - 1);

    crc_state_e        state;
    logic [CRC_W-1:0]  rcv_reg;
    logic [BCNT_W-1:0] bit_cnt;
    logic              lfsr_load;
    logic              lfsr_shift;

    // The CRC register only moves on data bits in CALC; from the first CRC
    // field bit on it stays frozen so it can be compared against rcv_reg.
    assign lfsr_load  = frm_start & ~abort;
    assign lfsr_shift = ~abort & ~frm_start & (state == CALC) & bit_vld & ~crc_fld;

    crc_serial_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .clk   (clk),
        .g_rst (g_rst),
        .load  (lfsr_load),
        .shift (lfsr_shift),
        .din   (bit_in),
        .crc   (crc_value)
    );

    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            state    <= IDLE;
            rcv_reg  <= '0;
            bit_cnt  <= '0;
            crc_done <= 1'b0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            crc_done <= 1'b0;
            crc_ok   <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                rcv_reg <= '0;
                bit_cnt <= '0;
                crc_err <= 1'b0;
            end else if (frm_start) begin
                state   <= CALC;
                rcv_reg <= '0;
                bit_cnt <= '0;
                crc_err <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    CALC: begin
                        if (bit_vld && crc_fld) begin
                            rcv_reg <= {rcv_reg[CRC_W-2:0], bit_in};
                            bit_cnt <= BCNT_W'(1);
                            state   <= RCV;
                        end
                    end
                    RCV: begin
                        if (bit_vld) begin
                            rcv_reg <= {rcv_reg[CRC_W-2:0], bit_in};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        crc_done <= 1'b1;
                        if (rcv_reg == crc_value) begin
                            crc_ok <= 1'b1;
                        end else if (chk_en) begin
                            crc_err <= 1'b1;
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc_field_checker.sv
// -----------------------------------------------------------------------------
// tb_crc_field_checker
// Directed bench for crc_field_checker configured as CRC-8 (poly 0x07,
// init 0x00) with a 2-bit error counter. The driver pushes the expected
// compare result for every completed frame; a monitor pops and compares on
// each crc_done/crc_ok pulse, including the cycle at which it appears.
// -----------------------------------------------------------------------------
module tb_crc_field_checker;

    localparam int unsigned CRC_W     = 8;
    localparam int unsigned ERR_CNT_W = 2;

    logic                 clk       = 1'b0;
    logic                 g_rst     = 1'b1;
    logic                 frm_start = 1'b0;
    logic                 abort     = 1'b0;
    logic                 bit_vld   = 1'b0;
    logic                 bit_in    = 1'b0;
    logic                 crc_fld   = 1'b0;
    logic                 chk_en    = 1'b1;
    logic [CRC_W-1:0]     crc_value;
    logic                 crc_done;
    logic                 crc_ok;
    logic                 crc_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    crc_field_checker #(
        .CRC_W     (CRC_W),
        .POLY      (32'h0000_0007),
        .INIT      (32'h0000_0000),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .g_rst     (g_rst),
        .frm_start (frm_start),
        .abort     (abort),
        .bit_vld   (bit_vld),
        .bit_in    (bit_in),
        .crc_fld   (crc_fld),
        .chk_en    (chk_en),
        .crc_value (crc_value),
        .crc_done  (crc_done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned          cyc;
        logic                 ok;
        logic                 err;
        logic [ERR_CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                            8'h36, 8'h37, 8'h38, 8'h39};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done/ok pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!g_rst && (crc_done || crc_ok)) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_done: got crc_done=%0b crc_ok=%0b at cycle %0d, want no pulse",
                         crc_done, crc_ok, cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("crc_done", crc_done, 1'b1);
                check("crc_ok", crc_ok, e.ok);
                check("crc_err", crc_err, e.err);
                check("err_cnt", err_cnt, e.cnt);
            end
        end
    end

    task automatic drive(input logic fs, input logic ab, input logic bv, input logic bi, input logic cf);
        @(posedge clk);
        #1;
        frm_start = fs;
        abort     = ab;
        bit_vld   = bv;
        bit_in    = bi;
        crc_fld   = cf;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic gap(input bit gaps);
        if (gaps) idle($urandom_range(0, 2));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            gap(gaps);
            drive(1'b0, 1'b0, 1'b1, b[i], 1'b0);
        end
    endtask

    task automatic send_data(input bit gaps);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) send_byte(msg[k], gaps);
    endtask

    task automatic send_field(input logic [7:0] f, input int nbits, input bit gaps,
                              output int unsigned last_cyc);
        last_cyc = 0;
        for (int i = 0; i < nbits; i++) begin
            gap(gaps);
            drive(1'b0, 1'b0, 1'b1, f[7-i], (i == 0));
            last_cyc = cyc;
        end
    endtask

    task automatic frame(input logic [7:0] f, input bit gaps, input logic ok,
                         input logic err, input logic [ERR_CNT_W-1:0] cnt);
        int unsigned lc;
        exp_t e;
        send_data(gaps);
        send_field(f, 8, gaps, lc);
        e.cyc = lc + 2;
        e.ok  = ok;
        e.err = err;
        e.cnt = cnt;
        exp_q.push_back(e);
        idle(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
        $fatal(1);
    end

    initial begin
        int unsigned lc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_crc_value", crc_value, 8'h00);
        check("rst_crc_done", crc_done, 1'b0);
        check("rst_crc_ok", crc_ok, 1'b0);
        check("rst_crc_err", crc_err, 1'b0);
        check("rst_err_cnt", err_cnt, 2'd0);
        @(posedge clk);
        #1;
        g_rst = 1'b0;

        // Golden CRC-8 of "123456789"
        frame(8'hF4, 1'b0, 1'b1, 1'b0, 2'd0);
        check("golden_crc_value", crc_value, 8'hF4);
        check("golden_crc_err", crc_err, 1'b0);

        // Mismatch with reporting; flag held, then cleared by frm_start
        frame(8'hF5, 1'b0, 1'b0, 1'b1, 2'd1);
        check("mism_err_held", crc_err, 1'b1);
        check("mism_crc_value", crc_value, 8'hF4);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("fs_clears_err", crc_err, 1'b0);
        check("fs_reload_init", crc_value, 8'h00);

        // Mismatch with reporting disabled
        chk_en = 1'b0;
        frame(8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
        check("nochk_err", crc_err, 1'b0);
        check("nochk_err_cnt", err_cnt, 2'd1);
        chk_en = 1'b1;

        // abort clears a held error but not the counter
        frame(8'hF5, 1'b0, 1'b0, 1'b1, 2'd2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("abort_clears_err", crc_err, 1'b0);
        check("abort_keeps_cnt", err_cnt, 2'd2);

        // Abort after 4 of 8 CRC field bits; trailing bits must be ignored
        send_data(1'b0);
        send_field(8'hF4, 4, 1'b0, lc);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        check("abort_rcv_err", crc_err, 1'b0);
        check("abort_rcv_value", crc_value, 8'hF4);

        // Following frame behaves normally
        frame(8'hF4, 1'b0, 1'b1, 1'b0, 2'd2);

        // abort + frm_start together: abort wins, bits in IDLE not hashed
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'h31, 1'b0);
        idle(1);
        check("abort_beats_fs", crc_value, 8'hF4);

        // frm_start + bit_vld together: the bit is dropped
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);
        check("fs_drops_bit", crc_value, 8'h00);

        // Hash one byte in CALC, then assert g_rst between clock edges
        send_byte(8'h31, 1'b0);
        idle(1);
        check("calc_byte_31", crc_value, 8'h97);
        @(posedge clk);
        #3;
        g_rst = 1'b1;
        #1;
        check("arst_crc_value", crc_value, 8'h00);
        check("arst_err_cnt", err_cnt, 2'd0);
        check("arst_crc_err", crc_err, 1'b0);
        check("arst_crc_done", crc_done, 1'b0);
        check("arst_crc_ok", crc_ok, 1'b0);
        @(posedge clk);
        #1;
        g_rst = 1'b0;

        // Saturation of the 2-bit counter with random bit_vld gaps
        frame(8'hF5, 1'b1, 1'b0, 1'b1, 2'd1);
        frame(8'hF5, 1'b1, 1'b0, 1'b1, 2'd2);
        frame(8'hF5, 1'b1, 1'b0, 1'b1, 2'd3);
        frame(8'hF5, 1'b1, 1'b0, 1'b1, 2'd3);
        frame(8'hF5, 1'b1, 1'b0, 1'b1, 2'd3);
        check("sat_err_cnt", err_cnt, 2'd3);
        check("sat_err_held", crc_err, 1'b1);

        // Every expected compare must have been observed
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL pending_done: got %0d unobserved compares, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
